rnn_ram_sequencer: RTL

//  Controller for the RNN node's 5-bank parameter RAM (W/H/U/X/V, 512 x 32b, 1-cycle registered read).

---
 rtl/rnn_ram_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rnn_ram_sequencer.sv
// Load/run sequencer for the RNN node's 5-bank parameter RAM.
// LOAD writes a valid/ready tuple stream to consecutive addresses; RUN sweeps reads with an aligned stream sideband.
module rnn_ram_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RAMSIZE = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_w,
    input  logic [DATA_W-1:0] load_h,
    input  logic [DATA_W-1:0] load_u,
    input  logic [DATA_W-1:0] load_x,
    input  logic [DATA_W-1:0] load_v,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wW,
    output logic [DATA_W-1:0] ram_wH,
    output logic [DATA_W-1:0] ram_wU,
    output logic [DATA_W-1:0] ram_wX,
    output logic [DATA_W-1:0] ram_wV,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              stream_valid,
    output logic              stream_last,
    output logic [ADDR_W-1:0] stream_idx,
    output logic              busy,
    output logic              load_done,
    output logic              run_done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(RAMSIZE);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len, len_in, last_idx;
    logic [ADDR_W-1:0] wcnt;
    logic              start_load, start_run, handshake, load_final;
    logic              run_turn, rd_active, rd_last;

    assign len_in     = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    assign last_idx   = len - ONE;
    // load_start has priority when both starts arrive together in IDLE
    assign start_load = (state == IDLE) && load_start;
    assign start_run  = (state == IDLE) && run_start && !load_start;
    assign handshake  = load_valid && load_ready;
    assign load_final = handshake && ({1'b0, wcnt} == last_idx);

    // RUN hands over to DRAIN while presenting the final address, so the
    // last read beat (and run_done) lands in IDLE and can be chained.
    assign run_turn  = (({1'b0, ram_raddr} + ONE) == last_idx);
    assign rd_active = (state == RUN) || (state == DRAIN);
    assign rd_last   = rd_active && ({1'b0, ram_raddr} == last_idx);

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_load && (len_in != '0)) begin
                    state_nxt = LOAD;
                end else if (start_run && (len_in != '0)) begin
                    state_nxt = (len_in == ONE) ? DRAIN : RUN;
                end
            end
            LOAD:    if (load_final) state_nxt = IDLE;
            RUN:     if (run_turn)   state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        if (state == LOAD) load_ready = 1'b1;
        if (state != IDLE) busy       = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len          <= '0;
            wcnt         <= '0;
            ram_we       <= 1'b0;
            ram_waddr    <= '0;
            ram_wW       <= '0;
            ram_wH       <= '0;
            ram_wU       <= '0;
            ram_wX       <= '0;
            ram_wV       <= '0;
            ram_raddr    <= '0;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
            stream_idx   <= '0;
            load_done    <= 1'b0;
            run_done     <= 1'b0;
        end else begin
            ram_we       <= handshake;
            load_done    <= 1'b0;
            run_done     <= 1'b0;
            stream_valid <= rd_active;
            stream_last  <= rd_last;

            if (start_load || start_run) len <= len_in;

            if (start_load) begin
                wcnt <= '0;
                if (len_in == '0) load_done <= 1'b1;
            end

            if (start_run) begin
                if (len_in == '0) run_done  <= 1'b1;
                else              ram_raddr <= '0;
            end

            // Write address and data hold between handshakes
            if (handshake) begin
                ram_waddr <= wcnt;
                ram_wW    <= load_w;
                ram_wH    <= load_h;
                ram_wU    <= load_u;
                ram_wX    <= load_x;
                ram_wV    <= load_v;
                wcnt      <= wcnt + ADDR_W'(1);
                if (load_final) load_done <= 1'b1;
            end

            if (state == RUN) ram_raddr <= ram_raddr + ADDR_W'(1);

            // Sideband is one cycle behind the address to match the RAM's registered read
            if (rd_active) stream_idx <= ram_raddr;
            if (rd_last)   run_done   <= 1'b1;
        end
    end

endmodule
